// File: rtl/pipe_flow_ctrl.sv
// Pipeline sequencing controller: stall, flush, exception/eret entry and HI/LO busy tracking.
// Controls are combinational from the registered state plus the current requests.
module pipe_flow_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ld_use_hazard,
    input  logic       md_start,
    input  logic       md_is_div,
    input  logic       md_use_D,
    input  logic       exc_req_M,
    input  logic       int_req,
    input  logic       eret_M,
    output logic       en_F,
    output logic       en_FD,
    output logic       en_DE,
    output logic       clr_DE,
    output logic       int_clr,
    output logic [1:0] pc_sel,
    output logic       epc_we,
    output logic       exl,
    output logic       md_busy
);

    localparam int unsigned CNT_W = 5;

    localparam logic [1:0] PC_SEQ     = 2'b00;
    localparam logic [1:0] PC_HANDLER = 2'b01;
    localparam logic [1:0] PC_EPC     = 2'b10;

    typedef enum logic [1:0] {
        NORMAL    = 2'b00,
        EXC_FLUSH = 2'b01,
        HANDLER   = 2'b10,
        RET_FLUSH = 2'b11
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   md_cnt;
    logic [CNT_W-1:0]   md_cnt_nxt;
    logic               cnt_busy;
    logic               active;
    logic               take;
    logic               stall;

    // State and HI/LO busy counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= NORMAL;
            md_cnt <= '0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
        end
    end

    // Next state, counter update and pipeline controls
    always_comb begin
        cnt_busy   = (md_cnt != '0);
        active     = (state == NORMAL) || (state == HANDLER);
        take       = active && (exc_req_M || (int_req && (state == NORMAL)));
        stall      = ld_use_hazard || (md_use_D && (cnt_busy || md_start));

        state_nxt  = state;
        md_cnt_nxt = md_cnt;
        en_F       = 1'b1;
        en_FD      = 1'b1;
        en_DE      = 1'b1;
        clr_DE     = 1'b0;
        int_clr    = 1'b0;
        pc_sel     = PC_SEQ;
        epc_we     = 1'b0;
        exl        = (state == EXC_FLUSH) || (state == HANDLER);
        md_busy    = cnt_busy;

        // A start squashed by take belongs to the flushed E-stage instruction
        if (md_start && !cnt_busy && !take) begin
            md_cnt_nxt = md_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (cnt_busy) begin
            md_cnt_nxt = md_cnt - CNT_W'(1);
        end

        case (state)
            NORMAL, HANDLER: begin
                if (take) begin
                    int_clr   = 1'b1;
                    pc_sel    = PC_HANDLER;
                    epc_we    = 1'b1;
                    state_nxt = EXC_FLUSH;
                end else if (eret_M) begin
                    int_clr   = 1'b1;
                    pc_sel    = PC_EPC;
                    state_nxt = RET_FLUSH;
                end else if (stall) begin
                    en_F   = 1'b0;
                    en_FD  = 1'b0;
                    clr_DE = 1'b1;
                end
            end
            EXC_FLUSH: begin
                clr_DE    = 1'b1;
                state_nxt = HANDLER;
            end
            RET_FLUSH: begin
                clr_DE    = 1'b1;
                state_nxt = NORMAL;
            end
            default: state_nxt = NORMAL;
        endcase

        // Reset overrides everything while it is held
        if (reset) begin
            state_nxt  = NORMAL;
            md_cnt_nxt = '0;
            en_F       = 1'b1;
            en_FD      = 1'b1;
            en_DE      = 1'b1;
            clr_DE     = 1'b0;
            int_clr    = 1'b0;
            pc_sel     = PC_SEQ;
            epc_we     = 1'b0;
            exl        = 1'b0;
            md_busy    = 1'b0;
        end
    end

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Self-checking bench for pipe_flow_ctrl: directed scenarios then randomized traffic
// against a behavioural model built from an exception-level bit and a flush-slot bit.
module tb_pipe_flow_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       ld_use_hazard;
    logic       md_start;
    logic       md_is_div;
    logic       md_use_D;
    logic       exc_req_M;
    logic       int_req;
    logic       eret_M;
    logic       en_F;
    logic       en_FD;
    logic       en_DE;
    logic       clr_DE;
    logic       int_clr;
    logic [1:0] pc_sel;
    logic       epc_we;
    logic       exl;
    logic       md_busy;

    int checks = 0;
    int errors = 0;

    // Model: in_exl = exception level, in_flush = this cycle is the one-cycle flush slot
    bit in_exl;
    bit in_flush;
    int remain;

    pipe_flow_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk           (clk),
        .reset         (reset),
        .ld_use_hazard (ld_use_hazard),
        .md_start      (md_start),
        .md_is_div     (md_is_div),
        .md_use_D      (md_use_D),
        .exc_req_M     (exc_req_M),
        .int_req       (int_req),
        .eret_M        (eret_M),
        .en_F          (en_F),
        .en_FD         (en_FD),
        .en_DE         (en_DE),
        .clr_DE        (clr_DE),
        .int_clr       (int_clr),
        .pc_sel        (pc_sel),
        .epc_we        (epc_we),
        .exl           (exl),
        .md_busy       (md_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp_v);
        end
    endtask

    task automatic drive(input bit r, input bit ld, input bit ms, input bit dv,
                         input bit mu, input bit ex, input bit ir, input bit er);
        reset         = r;
        ld_use_hazard = ld;
        md_start      = ms;
        md_is_div     = dv;
        md_use_D      = mu;
        exc_req_M     = ex;
        int_req       = ir;
        eret_M        = er;
    endtask

    // Check the current cycle against the model, then advance model and clock
    task automatic cycle();
        bit x_en_f, x_en_fd, x_en_de, x_clr, x_iclr, x_epc, x_exl, x_busy;
        bit [1:0] x_pc;
        bit taken, stalled, busy;
        #2;
        busy    = (remain > 0);
        taken   = 1'b0;
        x_en_f  = 1; x_en_fd = 1; x_en_de = 1; x_clr = 0; x_iclr = 0; x_epc = 0;
        x_pc    = 2'b00;
        x_exl   = in_exl;
        x_busy  = busy;
        if (reset) begin
            x_exl  = 0;
            x_busy = 0;
        end else if (in_flush) begin
            x_clr = 1;
        end else begin
            taken   = exc_req_M || (int_req && !in_exl);
            stalled = ld_use_hazard || (md_use_D && (busy || md_start));
            if (taken) begin
                x_iclr = 1; x_pc = 2'b01; x_epc = 1;
            end else if (eret_M) begin
                x_iclr = 1; x_pc = 2'b10;
            end else if (stalled) begin
                x_en_f = 0; x_en_fd = 0; x_clr = 1;
            end
        end
        chk("en_F",    {1'b0, en_F},    {1'b0, x_en_f});
        chk("en_FD",   {1'b0, en_FD},   {1'b0, x_en_fd});
        chk("en_DE",   {1'b0, en_DE},   {1'b0, x_en_de});
        chk("clr_DE",  {1'b0, clr_DE},  {1'b0, x_clr});
        chk("int_clr", {1'b0, int_clr}, {1'b0, x_iclr});
        chk("pc_sel",  pc_sel,          x_pc);
        chk("epc_we",  {1'b0, epc_we},  {1'b0, x_epc});
        chk("exl",     {1'b0, exl},     {1'b0, x_exl});
        chk("md_busy", {1'b0, md_busy}, {1'b0, x_busy});

        if (reset) begin
            in_exl = 0; in_flush = 0; remain = 0;
        end else begin
            if (md_start && remain == 0 && !taken) remain = md_is_div ? 10 : 5;
            else if (remain > 0) remain = remain - 1;
            if (in_flush) begin
                in_flush = 0;
            end else if (taken) begin
                in_exl = 1; in_flush = 1;
            end else if (eret_M) begin
                in_exl = 0; in_flush = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        in_exl = 0; in_flush = 0; remain = 0;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        cycle(); cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cycle(); cycle();

        // Divide start with a dependent instruction waiting in D
        drive(0, 0, 1, 1, 1, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        repeat (11) cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        // Multiply start, same pattern
        drive(0, 0, 1, 0, 1, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        repeat (6) cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        // Held interrupt, eret, re-entry
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        repeat (5) cycle();
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        repeat (2) cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) cycle();

        // Exception coinciding with a load-use stall
        drive(0, 1, 0, 0, 0, 1, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) cycle();

        // Divide in flight survives an exception, then reset aborts it
        drive(0, 0, 1, 1, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) cycle();
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) cycle();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) cycle();

        // Randomized traffic; starts only issue when the unit is idle outside flush slots
        for (int i = 0; i < 2000; i++) begin
            bit ms;
            ms = (remain == 0) && !in_flush && ($urandom_range(5) == 0);
            drive($urandom_range(99) == 0, $urandom_range(3) == 0, ms,
                  1'($urandom_range(1)), $urandom_range(2) == 0,
                  $urandom_range(19) == 0, $urandom_range(9) == 0,
                  $urandom_range(14) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
